// File: rtl/md_issue_ctrl.sv
// HI/LO multiply/divide issue control: issues md ops combinationally in IDLE, tracks mult/div latency,
// and holds later md requests on a combinational stall while the unit is occupied.
module md_issue_ctrl #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int OP_W     = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  input  logic [OP_W-1:0] req_op,
  input  logic [31:0]     req_a,
  input  logic [31:0]     req_b,
  input  logic            flush,
  output logic [OP_W-1:0] md_op,
  output logic [31:0]     md_a,
  output logic [31:0]     md_b,
  output logic            md_start,
  output logic            busy,
  output logic            stall,
  output logic [31:0]     stall_cnt
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  localparam logic [OP_W-1:0] OP_NONE  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_MULT  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_MULTU = OP_W'(2);
  localparam logic [OP_W-1:0] OP_DIV   = OP_W'(3);
  localparam logic [OP_W-1:0] OP_DIVU  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_MTLO  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_MTHI  = OP_W'(6);
  localparam logic [OP_W-1:0] OP_MFLO  = OP_W'(7);
  localparam logic [OP_W-1:0] OP_MFHI  = OP_W'(8);
  localparam logic [OP_W-1:0] OP_MSUB  = OP_W'(9);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_BUSY = 2'd1,
    DIV_BUSY = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        stall_cnt_q, stall_cnt_d;

  logic is_mul, is_div, is_long, is_wr, is_rd;
  logic act, idle, issue;

  always_comb begin
    is_mul  = (req_op == OP_MULT) || (req_op == OP_MULTU) || (req_op == OP_MSUB);
    is_div  = (req_op == OP_DIV)  || (req_op == OP_DIVU);
    is_wr   = (req_op == OP_MTLO) || (req_op == OP_MTHI);
    is_rd   = (req_op == OP_MFLO) || (req_op == OP_MFHI);
    is_long = is_mul || is_div;
    // A request presented during reset is dropped along with the state.
    act     = req_valid && !flush && !reset && (is_long || is_wr || is_rd);
    idle    = (state_q == IDLE);
    issue   = act && idle;
  end

  always_comb begin
    md_op    = OP_NONE;
    md_a     = '0;
    md_b     = '0;
    md_start = 1'b0;
    if (issue) begin
      md_op    = req_op;
      md_a     = req_a;
      md_b     = req_b;
      md_start = is_long;
    end
    stall     = act && !idle;
    busy      = !idle;
    stall_cnt = stall_cnt_q;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stall_cnt_d = stall_cnt_q + 32'(stall);
    case (state_q)
      IDLE: begin
        if (issue && is_mul) begin
          state_d = MUL_BUSY;
          cnt_d   = CNT_W'(MULT_LAT);
        end else if (issue && is_div) begin
          state_d = DIV_BUSY;
          cnt_d   = CNT_W'(DIV_LAT);
        end
      end
      MUL_BUSY, DIV_BUSY: begin
        // cnt==1 marks the last busy cycle; flush never cuts this short.
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed bench for md_issue_ctrl: hand-computed issue, stall, busy and counter expectations.
module tb_md_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [3:0]  req_op;
  logic [31:0] req_a, req_b;
  logic        flush;
  logic [3:0]  md_op;
  logic [31:0] md_a, md_b;
  logic        md_start, busy, stall;
  logic [31:0] stall_cnt;

  int vectors = 0;
  int errors  = 0;

  md_issue_ctrl #(.MULT_LAT(5), .DIV_LAT(10), .OP_W(4)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .flush(flush),
    .md_op(md_op), .md_a(md_a), .md_b(md_b), .md_start(md_start),
    .busy(busy), .stall(stall), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic fl);
    req_valid = v; req_op = op; req_a = a; req_b = b; flush = fl;
  endtask

  // Outputs are sampled on the falling edge; inputs change just after the rising edge.
  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b1, 4'd1, 32'd9, 32'd9, 1'b0);
    @(negedge clk);
    vectors++; if (md_start !== 1'b0) begin errors++; $display("FAIL rst_req_start got %0b want 0", md_start); end
    vectors++; if (md_op !== 4'd0) begin errors++; $display("FAIL rst_req_op got %0d want 0", md_op); end
    next_cycle();
    reset = 1'b0;
    drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0b want 0", busy); end
    vectors++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL rst_stall_cnt got %0d want 0", stall_cnt); end
    vectors++; if ({md_op, md_start, stall} !== 6'd0) begin errors++; $display("FAIL rst_outs got %h want 0", {md_op, md_start, stall}); end
    vectors++; if ({md_a, md_b} !== 64'd0) begin errors++; $display("FAIL rst_operands got %h want 0", {md_a, md_b}); end
    next_cycle();
  endtask

  task automatic test_mult();
    do_reset();
    drive(1'b1, 4'd1, 32'd3, 32'hFFFF_FFFE, 1'b0);
    @(negedge clk);
    vectors++; if (md_start !== 1'b1) begin errors++; $display("FAIL mult_start got %0b want 1", md_start); end
    vectors++; if (md_op !== 4'd1) begin errors++; $display("FAIL mult_op got %0d want 1", md_op); end
    vectors++; if (md_a !== 32'd3 || md_b !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mult_operands got %h %h want 3 fffffffe", md_a, md_b); end
    next_cycle();
    // mflo held at T+1..T+5 stalls every cycle including the last busy one.
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 4'd7, 32'd0, 32'd0, 1'b0);
      @(negedge clk);
      vectors++; if (stall !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL mult_busy_t%0d got stall=%0b busy=%0b want 1 1", i, stall, busy); end
      vectors++; if (md_op !== 4'd0 || md_start !== 1'b0) begin errors++; $display("FAIL mult_hold_t%0d got op=%0d start=%0b want 0 0", i, md_op, md_start); end
      next_cycle();
    end
    @(negedge clk);
    vectors++; if (busy !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL mult_t6 got busy=%0b stall=%0b want 0 0", busy, stall); end
    vectors++; if (md_op !== 4'd7 || md_start !== 1'b0) begin errors++; $display("FAIL mflo_issue got op=%0d start=%0b want 7 0", md_op, md_start); end
    next_cycle();
    drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    vectors++; if (stall_cnt !== 32'd5) begin errors++; $display("FAIL mult_stall_cnt got %0d want 5", stall_cnt); end
    vectors++; if (md_op !== 4'd0) begin errors++; $display("FAIL mult_after_op got %0d want 0", md_op); end
    next_cycle();
  endtask

  task automatic test_div();
    do_reset();
    drive(1'b1, 4'd3, 32'd7, 32'd2, 1'b0);
    @(negedge clk);
    vectors++; if (md_start !== 1'b1 || md_op !== 4'd3) begin errors++; $display("FAIL div_issue got start=%0b op=%0d want 1 3", md_start, md_op); end
    next_cycle();
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, 4'd8, 32'd0, 32'd0, 1'b0);
      @(negedge clk);
      vectors++; if (stall !== 1'b1 || md_op !== 4'd0) begin errors++; $display("FAIL div_stall_t%0d got stall=%0b op=%0d want 1 0", i, stall, md_op); end
      next_cycle();
    end
    @(negedge clk);
    vectors++; if (stall !== 1'b0 || md_op !== 4'd8) begin errors++; $display("FAIL mfhi_issue got stall=%0b op=%0d want 0 8", stall, md_op); end
    next_cycle();
    drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    vectors++; if (md_op !== 4'd0) begin errors++; $display("FAIL mfhi_once got %0d want 0", md_op); end
    vectors++; if (stall_cnt !== 32'd10) begin errors++; $display("FAIL div_stall_cnt got %0d want 10", stall_cnt); end
    next_cycle();
  endtask

  task automatic test_rdwr();
    do_reset();
    drive(1'b1, 4'd5, 32'h55, 32'd0, 1'b0);
    @(negedge clk);
    vectors++; if (md_op !== 4'd5 || md_a !== 32'h55) begin errors++; $display("FAIL mtlo got op=%0d a=%h want 5 55", md_op, md_a); end
    vectors++; if (md_start !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL mtlo_ctl got start=%0b stall=%0b want 0 0", md_start, stall); end
    next_cycle();
    drive(1'b1, 4'd7, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    vectors++; if (md_op !== 4'd7 || stall !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mflo_b2b got op=%0d stall=%0b busy=%0b want 7 0 0", md_op, stall, busy); end
    next_cycle();
    drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    vectors++; if (busy !== 1'b0 || stall_cnt !== 32'd0) begin errors++; $display("FAIL rdwr_end got busy=%0b cnt=%0d want 0 0", busy, stall_cnt); end
    next_cycle();
  endtask

  task automatic test_flush();
    do_reset();
    drive(1'b1, 4'd2, 32'd4, 32'd5, 1'b0);
    @(negedge clk);
    vectors++; if (md_start !== 1'b1 || md_op !== 4'd2) begin errors++; $display("FAIL multu_issue got start=%0b op=%0d want 1 2", md_start, md_op); end
    next_cycle();
    drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    next_cycle();
    drive(1'b1, 4'd8, 32'd0, 32'd0, 1'b1);
    @(negedge clk);
    vectors++; if (stall !== 1'b0 || md_op !== 4'd0 || busy !== 1'b1) begin errors++; $display("FAIL flush_t2 got stall=%0b op=%0d busy=%0b want 0 0 1", stall, md_op, busy); end
    next_cycle();
    drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    next_cycle();
    next_cycle();
    @(negedge clk);
    vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_t5_busy got %0b want 1", busy); end
    next_cycle();
    @(negedge clk);
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_t6_busy got %0b want 0", busy); end
    vectors++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL flush_stall_cnt got %0d want 0", stall_cnt); end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(1'b1, 4'd3, 32'd7, 32'd2, 1'b0);
    next_cycle();
    drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    next_cycle();
    next_cycle();
    reset = 1'b1;
    drive(1'b1, 4'd7, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    vectors++; if (md_op !== 4'd0 || stall_cnt !== 32'd0) begin errors++; $display("FAIL rstmid_req got op=%0d cnt=%0d want 0 0", md_op, stall_cnt); end
    next_cycle();
    reset = 1'b0;
    drive(1'b1, 4'd1, 32'd6, 32'd7, 1'b0);
    @(negedge clk);
    vectors++; if (busy !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL rstmid_t4 got busy=%0b stall=%0b want 0 0", busy, stall); end
    vectors++; if (md_start !== 1'b1 || md_op !== 4'd1) begin errors++; $display("FAIL rstmid_mult got start=%0b op=%0d want 1 1", md_start, md_op); end
    next_cycle();
    drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    for (int i = 0; i < 5; i++) next_cycle();
    @(negedge clk);
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_done got %0b want 0", busy); end
    next_cycle();
  endtask

  task automatic test_none();
    do_reset();
    drive(1'b1, 4'd12, 32'hAA, 32'hBB, 1'b0);
    @(negedge clk);
    vectors++; if ({md_op, md_start, stall} !== 6'd0 || md_a !== 32'd0) begin errors++; $display("FAIL none_idle got op=%0d start=%0b stall=%0b a=%h want 0", md_op, md_start, stall, md_a); end
    next_cycle();
    drive(1'b1, 4'd9, 32'd1, 32'd1, 1'b0);
    @(negedge clk);
    vectors++; if (md_start !== 1'b1 || md_op !== 4'd9) begin errors++; $display("FAIL msub_issue got start=%0b op=%0d want 1 9", md_start, md_op); end
    next_cycle();
    drive(1'b1, 4'd0, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    vectors++; if (stall !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL none_busy got stall=%0b busy=%0b want 0 1", stall, busy); end
    next_cycle();
    drive(1'b1, 4'd15, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    vectors++; if (stall !== 1'b0 || md_op !== 4'd0) begin errors++; $display("FAIL op15_busy got stall=%0b op=%0d want 0 0", stall, md_op); end
    next_cycle();
    drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    for (int i = 0; i < 4; i++) next_cycle();
    @(negedge clk);
    vectors++; if (busy !== 1'b0 || stall_cnt !== 32'd0) begin errors++; $display("FAIL none_end got busy=%0b cnt=%0d want 0 0", busy, stall_cnt); end
    next_cycle();
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    next_cycle();
    test_reset();
    test_mult();
    test_div();
    test_rdwr();
    test_flush();
    test_reset_mid();
    test_none();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
